// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-side definitions: data width, the NOP used to fill
// empty decode slots, and the entry format carried from fetch to decode.
package rv32i_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic            misalign;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched instructions for decode.
// Flush empties it in one edge. Push and pop may coincide at any occupancy,
// including full, because the producer only pushes when it holds a credit.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  entry_t                   push_data_i,
    output entry_t                   head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wrPtr;
    logic [PW-1:0]   r_rdPtr;
    logic [PW:0]     r_count;

    // Pointer and occupancy bookkeeping; flush wins over push/pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (push_i) r_wrPtr <= r_wrPtr + 1'b1;
            if (pop_i)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset since empty gates every read
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) r_mem[r_wrPtr] <= push_data_i;
    end

    assign head_o  = r_mem[r_rdPtr];
    assign count_o = r_count;
    assign full_o  = (r_count == (PW+1)'(DEPTH));
    assign empty_o = (r_count == '0);

    // A push into a full queue without a matching pop would lose data
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     !(push_i && !pop_i && !flush_i && full_o));

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage back end: issues one imem read per cycle while credit exists,
// captures the 1-cycle-latency response into a queue for decode, stalls the
// PC when out of credit and drops all queued/in-flight work on a redirect.
// XLEN and NOP_INSTR come from rv32i_pkg.
module if_fetch_queue
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc4_i,
    input  logic            redirect_i,
    output logic            pc_stall_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_pc4_o,
    output logic            id_misalign_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_space;
    fetch_entry_t    w_head;
    fetch_entry_t    w_pushData;

    logic            r_inflight;
    logic            r_kill;
    logic [XLEN-1:0] r_reqPc;
    logic [XLEN-1:0] r_reqPc4;
    logic            r_reqMis;
    logic [XLEN-1:0] r_holdPc;
    logic [XLEN-1:0] r_holdPc4;

    // Credit: free slots minus the outstanding request, plus the slot freed
    // by a pop this cycle. The count plus in-flight never exceeds DEPTH.
    assign w_pop   = !w_empty && id_ready_i;
    assign w_space = CW'(DEPTH) - w_count - CW'(r_inflight) + CW'(w_pop);
    assign w_issue = rst_ni && (w_space != '0) && !redirect_i;

    assign imem_req_o  = w_issue;
    assign imem_addr_o = {pc_i[XLEN-1:2], 2'b00};
    assign pc_stall_o  = !rst_ni || (!w_issue && !redirect_i);

    assign w_push     = r_inflight && !r_kill;
    assign w_pushData = '{instr: imem_rdata_i, pc: r_reqPc, pc4: r_reqPc4, misalign: r_reqMis};

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (w_push),
        .pop_i       (w_pop),
        .flush_i     (redirect_i),
        .push_data_i (w_pushData),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (w_count)
    );

    // Outstanding request tracking; a redirect marks the next response as dead
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
            r_reqPc    <= '0;
            r_reqPc4   <= '0;
            r_reqMis   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_kill     <= redirect_i;
            if (w_issue) begin
                r_reqPc  <= pc_i;
                r_reqPc4 <= pc4_i;
                r_reqMis <= |pc_i[1:0];
            end
        end
    end

    // Remember the last head PC shown so it stays stable while the queue is empty
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_holdPc  <= '0;
            r_holdPc4 <= '0;
        end else if (!w_empty) begin
            r_holdPc  <= w_head.pc;
            r_holdPc4 <= w_head.pc4;
        end
    end

    assign id_valid_o    = !w_empty;
    assign id_instr_o    = w_empty ? NOP_INSTR : w_head.instr;
    assign id_pc_o       = w_empty ? r_holdPc  : w_head.pc;
    assign id_pc4_o      = w_empty ? r_holdPc4 : w_head.pc4;
    assign id_misalign_o = !w_empty && w_head.misalign;

    // A full queue may only accept a new request when the head leaves this cycle
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     w_full |-> (!w_issue || w_pop));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue. Acts as PC_block and instruction memory, and
// predicts every output from a queue-level model of the fetch rules.
module tb_if_fetch_queue;

    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] pc_i;
    logic [31:0] pc4_i;
    logic        redirect_i;
    logic        pc_stall_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc4_o;
    logic        id_misalign_o;

    if_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .pc_i          (pc_i),
        .pc4_i         (pc4_i),
        .redirect_i    (redirect_i),
        .pc_stall_o    (pc_stall_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .id_pc4_o      (id_pc4_o),
        .id_misalign_o (id_misalign_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        mis;
    } modelEntry_t;

    modelEntry_t mQueue[$];
    logic        mInfl;
    logic [31:0] mInflPc;
    logic [31:0] mInflPc4;
    logic        mInflMis;
    logic [31:0] mLastPc;
    logic [31:0] mLastPc4;

    logic        expIssue;
    logic        expStall;
    logic        expPop;
    logic [31:0] pcReg;
    logic [31:0] rdataNext;
    logic        randomData;

    int vectors     = 0;
    int miscompares = 0;

    // Forget everything, as a reset does
    task automatic modelReset();
        mQueue.delete();
        mInfl    = 1'b0;
        mInflPc  = '0;
        mInflPc4 = '0;
        mInflMis = 1'b0;
        mLastPc  = '0;
        mLastPc4 = '0;
    endtask

    // Predict this cycle's outputs from the model and compare them with the DUT
    task automatic checkOutput();
        logic        eValid;
        logic [31:0] eInstr;
        logic [31:0] ePc;
        logic [31:0] ePc4;
        logic [31:0] eAddr;
        logic        eMis;
        int          space;

        eValid = (mQueue.size() != 0);
        eInstr = eValid ? mQueue[0].instr : 32'h0000_0013;
        ePc    = eValid ? mQueue[0].pc    : mLastPc;
        ePc4   = eValid ? mQueue[0].pc4   : mLastPc4;
        eMis   = eValid ? mQueue[0].mis   : 1'b0;
        eAddr  = pc_i & 32'hFFFF_FFFC;
        expPop = eValid && id_ready_i;
        space  = DEPTH - mQueue.size() - int'(mInfl) + int'(expPop);
        expIssue = rst_ni && (space > 0) && !redirect_i;
        expStall = !rst_ni || (!expIssue && !redirect_i);

        vectors++;
        assert (id_valid_o === eValid) else begin
            miscompares++;
            $error("[TB] FAIL id_valid: observed %0b expected %0b", id_valid_o, eValid);
        end
        vectors++;
        assert (id_instr_o === eInstr) else begin
            miscompares++;
            $error("[TB] FAIL id_instr: observed %h expected %h", id_instr_o, eInstr);
        end
        vectors++;
        assert (id_pc_o === ePc) else begin
            miscompares++;
            $error("[TB] FAIL id_pc: observed %h expected %h", id_pc_o, ePc);
        end
        vectors++;
        assert (id_pc4_o === ePc4) else begin
            miscompares++;
            $error("[TB] FAIL id_pc4: observed %h expected %h", id_pc4_o, ePc4);
        end
        vectors++;
        assert (id_misalign_o === eMis) else begin
            miscompares++;
            $error("[TB] FAIL id_misalign: observed %0b expected %0b", id_misalign_o, eMis);
        end
        vectors++;
        assert (imem_req_o === expIssue) else begin
            miscompares++;
            $error("[TB] FAIL imem_req: observed %0b expected %0b", imem_req_o, expIssue);
        end
        vectors++;
        assert (pc_stall_o === expStall) else begin
            miscompares++;
            $error("[TB] FAIL pc_stall: observed %0b expected %0b", pc_stall_o, expStall);
        end
        vectors++;
        assert (imem_addr_o === eAddr) else begin
            miscompares++;
            $error("[TB] FAIL imem_addr: observed %h expected %h", imem_addr_o, eAddr);
        end
    endtask

    // One clock cycle: drive PC_block/imem/decode inputs, check, advance model
    task automatic applyStimulus(input logic redir, input logic rdy, input logic [31:0] target);
        redirect_i   = redir;
        id_ready_i   = rdy;
        pc_i         = pcReg;
        pc4_i        = pcReg + 32'd4;
        imem_rdata_i = rdataNext;
        #1;
        checkOutput();

        if (!rst_ni) begin
            modelReset();
        end else begin
            if (mQueue.size() != 0) begin
                mLastPc  = mQueue[0].pc;
                mLastPc4 = mQueue[0].pc4;
            end
            if (redir) begin
                mQueue.delete();
            end else begin
                if (expPop) mQueue.delete(0);
                if (mInfl) mQueue.push_back('{instr: imem_rdata_i, pc: mInflPc, pc4: mInflPc4, mis: mInflMis});
            end
            mInfl = expIssue;
            if (expIssue) begin
                mInflPc  = pcReg;
                mInflPc4 = pcReg + 32'd4;
                mInflMis = (pcReg[1:0] != 2'b00);
            end
        end

        rdataNext = randomData ? $urandom : ((pcReg & 32'hFFFF_FFFC) ^ 32'hA5A5_0000);
        if (redir)          pcReg = target;
        else if (!expStall) pcReg = pcReg + 32'd4;

        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        rst_ni       = 1'b0;
        redirect_i   = 1'b0;
        id_ready_i   = 1'b0;
        pc_i         = '0;
        pc4_i        = 32'd4;
        imem_rdata_i = '0;
        pcReg        = '0;
        rdataNext    = '0;
        randomData   = 1'b0;
        modelReset();
        @(negedge clk_i);

        // Reset state, then stream pc 0,4,8,... with decode always ready
        repeat (2) applyStimulus(1'b0, 1'b1, 32'h0);
        rst_ni = 1'b1;
        repeat (6) applyStimulus(1'b0, 1'b1, 32'h0);

        // Decode back-pressure fills the queue and stalls the PC, then drains
        repeat (10) applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (5)  applyStimulus(1'b0, 1'b1, 32'h0);

        // Redirect while queue and imem are busy
        applyStimulus(1'b1, 1'b1, 32'h1234_5600);
        repeat (5) applyStimulus(1'b0, 1'b1, 32'h0);
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h1234_5600);
        repeat (5) applyStimulus(1'b0, 1'b1, 32'h0);

        // Back-to-back redirects: only the second target survives
        applyStimulus(1'b1, 1'b1, 32'h8765_4300);
        applyStimulus(1'b1, 1'b1, 32'hA5A5_A500);
        repeat (5) applyStimulus(1'b0, 1'b1, 32'h0);

        // Misaligned PC
        applyStimulus(1'b1, 1'b1, 32'h0000_0002);
        repeat (4) applyStimulus(1'b0, 1'b1, 32'h0);

        // Asynchronous reset with a full queue, then restart
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);
        rst_ni = 1'b0;
        modelReset();
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0);
        rst_ni = 1'b1;
        repeat (6) applyStimulus(1'b0, 1'b1, 32'h0);

        // Random traffic: random data, ready, redirects and targets
        randomData = 1'b1;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
